// File: rtl/prv32_pkg.sv
// Shared constants and types for the prv32 iterative divider.
package prv32_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_ITERS = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIN
   } div_state_t;

endpackage

// File: rtl/prv32_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract |b|.
module prv32_div_step
   import prv32_pkg::*;
(
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] b_abs,
   output logic [XLEN:0]   rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN+1:0] rem_shift;
   logic [XLEN+1:0] diff;

   // One extra bit above the shifted remainder makes diff's MSB a clean borrow flag.
   always_comb begin
      rem_shift = {rem, quo[XLEN-1]};
      diff      = rem_shift - {2'b00, b_abs};
      quo_next  = {quo[XLEN-2:0], 1'b0};
      rem_next  = rem_shift[XLEN:0];
      if (!diff[XLEN+1]) begin
         rem_next    = diff[XLEN:0];
         quo_next[0] = 1'b1;
      end
   end

endmodule

// File: rtl/prv32_div_unit.sv
// RV32M DIV/DIVU/REM/REMU multi-cycle restoring divider (33-cycle latency).
// Define PRV32_DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module prv32_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      Function3,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] r
);
   import prv32_pkg::*;

   div_state_t state, state_next;

   logic            is_rem_q, neg_quo_q, neg_rem_q, div_zero_q, ovf_q;
   logic [XLEN-1:0] a_q, b_abs_q, quo_q, r_q;
   logic [XLEN:0]   rem_q;
   logic [4:0]      cnt_q;
   logic            done_q;

   logic            signed_op, accept, div_zero_in, ovf_in;
   logic [XLEN-1:0] a_abs, b_abs;
   logic [XLEN:0]   rem_next;
   logic [XLEN-1:0] quo_next, quo_fix, rem_fix, result;

   always_comb begin
      signed_op   = ~Function3[0];
      accept      = (state == IDLE) && start && Function3[2];
      a_abs       = (signed_op && a[XLEN-1]) ? -a : a;
      b_abs       = (signed_op && b[XLEN-1]) ? -b : b;
      div_zero_in = (b == '0);
      ovf_in      = signed_op && (a == INT_MIN) && (b == '1);
   end

   prv32_div_step u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .b_abs    (b_abs_q),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef PRV32_DIV_EARLY_OUT_EN
               state_next = (div_zero_in || ovf_in) ? FIN : ITER;
`else
               state_next = ITER;
`endif
            end
         end
         ITER:    if (cnt_q == 5'(DIV_ITERS - 1)) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Special cases override the iterated result so both builds return identical values.
   always_comb begin
      quo_fix = neg_quo_q ? -quo_q : quo_q;
      rem_fix = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
      result  = is_rem_q ? rem_fix : quo_fix;
      if (div_zero_q)  result = is_rem_q ? a_q : '1;
      else if (ovf_q)  result = is_rem_q ? '0 : INT_MIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_rem_q   <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         a_q        <= '0;
         b_abs_q    <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         r_q        <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  is_rem_q   <= Function3[1];
                  neg_quo_q  <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                  neg_rem_q  <= signed_op && a[XLEN-1];
                  div_zero_q <= div_zero_in;
                  ovf_q      <= ovf_in;
                  a_q        <= a;
                  b_abs_q    <= b_abs;
                  quo_q      <= a_abs;
                  rem_q      <= '0;
                  cnt_q      <= '0;
               end
            end
            ITER: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               cnt_q <= cnt_q + 5'd1;
            end
            FIN: begin
               r_q    <= result;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = done_q;
   assign r    = r_q;

endmodule

// File: tb/tb_prv32_div_unit.sv
// Scoreboard testbench for prv32_div_unit: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_prv32_div_unit;
   import prv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic [2:0]  Function3;
   logic        busy, done;
   logic [31:0] r;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] exp_q[$];
   int          cyc_q[$];
   int          lat_q[$];

   logic [31:0] mon_exp;
   int          mon_cyc, mon_lat;

   prv32_div_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .Function3 (Function3),
      .busy      (busy),
      .done      (done),
      .r         (r)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
      logic ovf;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (f3)
         F3_DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(x) / $signed(y));
         F3_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         F3_REM:  return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
`ifdef PRV32_DIV_EARLY_OUT_EN
      if (y == 0) return 1;
      if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`endif
      return 33;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Must be called at a negedge; returns at the following negedge.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y, input bit accept);
      start     = 1'b1;
      Function3 = f3;
      a         = x;
      b         = y;
      @(negedge clk);
      start = 1'b0;
      if (accept) begin
         exp_q.push_back(ref_model(f3, x, y));
         cyc_q.push_back(cyc);
         lat_q.push_back(ref_lat(f3, x, y));
      end
   endtask

   task automatic failTimeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: got timeout, expected completion within 100 cycles", name);
      exp_q.delete();
      cyc_q.delete();
      lat_q.delete();
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) failTimeout("wait_idle");
      @(negedge clk);
   endtask

   task automatic waitDone();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 100);
      if (n >= 100) failTimeout("wait_done");
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports completion.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got done=1 with r=0x%08h, expected no pending op", r);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_cyc = cyc_q.pop_front();
            mon_lat = lat_q.pop_front();
            checkOutput("result", r, mon_exp);
            checkOutput("latency", 32'(cyc - mon_cyc), 32'(mon_lat));
            checkOutput("busy_at_done", {31'b0, busy}, 32'h0);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] x, y;
      int          sel;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; Function3 = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", {31'b0, busy}, 32'h0);
      checkOutput("reset_done", {31'b0, done}, 32'h0);
      checkOutput("reset_r", r, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed operations");
      applyStimulus(F3_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1);          waitIdle();
      applyStimulus(F3_REM,  32'hFFFF_FFF9, 32'd2, 1'b1);          waitIdle();
      applyStimulus(F3_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1);         waitIdle();
      applyStimulus(F3_REMU, 32'hFFFF_FFFF, 32'h10, 1'b1);         waitIdle();
      applyStimulus(F3_DIV,  32'h1234, 32'h0, 1'b1);               waitIdle();
      applyStimulus(F3_DIVU, 32'h1234, 32'h0, 1'b1);               waitIdle();
      applyStimulus(F3_REM,  32'h1234, 32'h0, 1'b1);               waitIdle();
      applyStimulus(F3_REMU, 32'h1234, 32'h0, 1'b1);               waitIdle();
      applyStimulus(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  waitIdle();
      applyStimulus(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  waitIdle();

      $display("[TB] start while busy is ignored");
      applyStimulus(F3_DIVU, 32'd100, 32'd7, 1'b1);
      repeat (9) @(negedge clk);
      applyStimulus(F3_DIV, 32'd5, 32'd5, 1'b0);
      waitIdle();

      $display("[TB] back-to-back start in done cycle");
      applyStimulus(F3_REMU, 32'd1000, 32'd7, 1'b1);
      waitDone();
      applyStimulus(F3_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
      waitIdle();

      $display("[TB] non-divide Function3 is ignored");
      applyStimulus(3'b001, 32'd9, 32'd3, 1'b0);
      checkOutput("f3_ignored_busy", {31'b0, busy}, 32'h0);
      repeat (40) @(negedge clk);

      $display("[TB] reset mid-operation");
      applyStimulus(F3_DIV, 32'd12345, 32'd67, 1'b1);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {31'b0, busy}, 32'h0);
      checkOutput("abort_done", {31'b0, done}, 32'h0);
      checkOutput("abort_r", r, 32'h0);
      exp_q.delete(); cyc_q.delete(); lat_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(F3_REM, 32'hFFFF_CFC7, 32'd67, 1'b1);
      waitIdle();

      $display("[TB] randomized operations");
      for (int i = 0; i < 24; i++) begin
         f3  = 3'(4 + $urandom_range(0, 3));
         x   = $urandom;
         y   = $urandom >> $urandom_range(0, 31);
         sel = $urandom_range(0, 9);
         if (sel == 0) y = 32'h0;
         else if (sel == 1) y = 32'hFFFF_FFFF;
         else if (sel == 2) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
         applyStimulus(f3, x, y, 1'b1);
         waitIdle();
      end

      checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
